// File: rtl/ddr_addr_gen.sv
// DDR2 ring-buffer address generator: pairs input-FIFO words into MIG write-data entries and issues burst commands.
// Defining DDR_ADDR_GEN_STATS_EN adds wr_cmd_total/rd_cmd_total counters and a sticky pack_err flag.
module ddr_addr_gen #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 31,
    parameter int BURST_LEN       = 8,
    parameter int WORDS_PER_BURST = 4,
    parameter int BASE_ADDR       = 0,
    parameter int RING_BURSTS     = 1024
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic                          phy_init_done,
    input  logic                          wr_fifo_rd,
    input  logic [DATA_WIDTH-1:0]         fifo_dout,
    input  logic                          wr_addr_en,
    input  logic                          rd_addr_en,
    input  logic                          app_af_afull,
    output logic                          app_af_wren,
    output logic [2:0]                    app_af_cmd,
    output logic [ADDR_WIDTH-1:0]         app_af_addr,
    output logic                          app_wdf_wren,
    output logic [2*DATA_WIDTH-1:0]       app_wdf_data,
    output logic [DATA_WIDTH/4-1:0]       app_wdf_mask_data,
    output logic                          addr_conflict,
    output logic                          ring_full,
    output logic                          overflow,
`ifdef DDR_ADDR_GEN_STATS_EN
    output logic [31:0]                   wr_cmd_total,
    output logic [31:0]                   rd_cmd_total,
    output logic                          pack_err,
`endif
    output logic [$clog2(RING_BURSTS):0]  level
);
    localparam int PW = $clog2(RING_BURSTS);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]         RING_LVL = LW'(RING_BURSTS);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP_A   = ADDR_WIDTH'(BURST_LEN);

    if ((WORDS_PER_BURST < 2) || ((WORDS_PER_BURST % 2) != 0)) begin : g_bad_wpb
        $error("WORDS_PER_BURST must be even and at least 2");
    end
    if ((RING_BURSTS < 2) || ((RING_BURSTS & (RING_BURSTS - 1)) != 0)) begin : g_bad_ring
        $error("RING_BURSTS must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WR   = 2'd1,
        C_RD   = 2'd2
    } cmd_state_t;

    logic                  d_vld_r;
    logic                  half_r;
    logic [DATA_WIDTH-1:0] low_r;

    cmd_state_t            state_r, state_s;
    logic                  wr_pend_r, wr_pend_s;
    logic                  rd_pend_r, rd_pend_s;
    logic [PW-1:0]         wr_ptr_r, wr_ptr_s;
    logic [PW-1:0]         rd_ptr_r, rd_ptr_s;
    logic [LW-1:0]         level_r, level_s;
    logic                  ovf_set_s;
    logic                  af_wren_s;
    logic [2:0]            af_cmd_s;
    logic [ADDR_WIDTH-1:0] af_addr_s;
    logic                  wr_req_s, rd_req_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;

    assign wr_req_s  = wr_addr_en & phy_init_done;
    assign rd_req_s  = rd_addr_en & phy_init_done;
    assign wr_addr_s = BASE_A + ADDR_WIDTH'(wr_ptr_r) * STEP_A;
    assign rd_addr_s = BASE_A + ADDR_WIDTH'(rd_ptr_r) * STEP_A;
    assign level     = level_r;
    assign app_wdf_mask_data = {(DATA_WIDTH/4){1'b0}};

    // Packer: FIFO data is valid the cycle after the read strobe; first word of a pair is the low half.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            d_vld_r      <= 1'b0;
            half_r       <= 1'b0;
            low_r        <= {DATA_WIDTH{1'b0}};
            app_wdf_wren <= 1'b0;
            app_wdf_data <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            d_vld_r      <= wr_fifo_rd & phy_init_done;
            app_wdf_wren <= d_vld_r & half_r;
            if (d_vld_r) begin
                half_r <= ~half_r;
                if (half_r) begin
                    app_wdf_data <= {fifo_dout, low_r};
                end else begin
                    low_r <= fifo_dout;
                end
            end
        end
    end

    // Command next-state: writes win over reads; a new strobe during completion re-arms its pend flag.
    always_comb begin
        state_s   = state_r;
        wr_pend_s = wr_pend_r | wr_req_s;
        rd_pend_s = rd_pend_r | rd_req_s;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        level_s   = level_r;
        ovf_set_s = 1'b0;
        af_wren_s = 1'b0;
        af_cmd_s  = app_af_cmd;
        af_addr_s = app_af_addr;
        case (state_r)
            C_IDLE: begin
                if (!app_af_afull && wr_pend_r) begin
                    state_s   = C_WR;
                    af_wren_s = 1'b1;
                    af_cmd_s  = 3'b000;
                    af_addr_s = wr_addr_s;
                end else if (!app_af_afull && rd_pend_r && (level_r != LW'(0))) begin
                    state_s   = C_RD;
                    af_wren_s = 1'b1;
                    af_cmd_s  = 3'b001;
                    af_addr_s = rd_addr_s;
                end else begin
                    state_s = C_IDLE;
                end
            end
            C_WR: begin
                state_s   = C_IDLE;
                wr_pend_s = wr_req_s;
                wr_ptr_s  = wr_ptr_r + PW'(1);
                if (level_r == RING_LVL) begin
                    rd_ptr_s  = rd_ptr_r + PW'(1);
                    ovf_set_s = 1'b1;
                end else begin
                    level_s = level_r + LW'(1);
                end
            end
            C_RD: begin
                state_s   = C_IDLE;
                rd_pend_s = rd_req_s;
                rd_ptr_s  = rd_ptr_r + PW'(1);
                level_s   = level_r - LW'(1);
            end
            default: begin
                state_s = C_IDLE;
            end
        endcase
    end

    // Command state, ring bookkeeping and registered MIG/status outputs.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_r       <= C_IDLE;
            wr_pend_r     <= 1'b0;
            rd_pend_r     <= 1'b0;
            wr_ptr_r      <= PW'(0);
            rd_ptr_r      <= PW'(0);
            level_r       <= LW'(0);
            app_af_wren   <= 1'b0;
            app_af_cmd    <= 3'b000;
            app_af_addr   <= {ADDR_WIDTH{1'b0}};
            addr_conflict <= 1'b0;
            ring_full     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_pend_r     <= wr_pend_s;
            rd_pend_r     <= rd_pend_s;
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            level_r       <= level_s;
            app_af_wren   <= af_wren_s;
            app_af_cmd    <= af_cmd_s;
            app_af_addr   <= af_addr_s;
            addr_conflict <= (level_s == LW'(0)) | rd_pend_s;
            ring_full     <= (level_s == RING_LVL);
            overflow      <= overflow | ovf_set_s;
        end
    end

`ifdef DDR_ADDR_GEN_STATS_EN
    // Command totals wrap naturally; pack_err flags a write command arriving with half a data word packed.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_cmd_total <= 32'd0;
            rd_cmd_total <= 32'd0;
            pack_err     <= 1'b0;
        end else begin
            if (state_r == C_WR) begin
                wr_cmd_total <= wr_cmd_total + 32'd1;
            end
            if (state_r == C_RD) begin
                rd_cmd_total <= rd_cmd_total + 32'd1;
            end
            pack_err <= pack_err | (wr_req_s & half_r);
        end
    end
`endif

endmodule
